// File: rtl/regfile_writeback.sv
// Write-side front end of the 8 x 24-bit MIPS register file: buffers completed
// results in a small FIFO, drains one per cycle onto Rw/BusW/enWrite, and tracks pending writes.
module regfile_writeback #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_W-1:0]    in_rd,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_rd,
  input  logic                 pop_stall,
  output logic [2**ADDR_W-1:0] busy,
  output logic [ADDR_W-1:0]    Rw,
  output logic [DATA_W-1:0]    BusW,
  output logic                 enWrite,
  output logic [7:0]           r0_drop_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NREG  = 2**ADDR_W;

  logic [ADDR_W-1:0] mem_rd   [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              full;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;
  logic [NREG-1:0]   busy_next;

  // Pop depends only on pre-edge occupancy, so a full FIFO never passes a new result straight through.
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign pop       = (count != '0) && !pop_stall;
  assign head_rd   = mem_rd[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= in_rd;
      mem_data[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Writes to R0 are consumed from the FIFO but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Rw          <= '0;
      BusW        <= '0;
      enWrite     <= 1'b0;
      r0_drop_cnt <= '0;
    end else if (pop) begin
      Rw      <= head_rd;
      BusW    <= head_data;
      enWrite <= (head_rd != '0);
      if (head_rd == '0 && r0_drop_cnt != 8'hFF)
        r0_drop_cnt <= r0_drop_cnt + 8'd1;
    end else begin
      enWrite <= 1'b0;
    end
  end

  // Clear on commit first so a same-edge issue to that register keeps it busy.
  always_comb begin
    busy_next = busy;
    if (enWrite)
      busy_next[Rw] = 1'b0;
    if (issue_valid && issue_rd != '0)
      busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

endmodule
